wishbone_bus_if: RTL and testbench
==================================

# wishbone_bus_if

Bus bridge between the CPU core's single-cycle memory ports (instruction side `rom_*` or data side `ram_*`) and a classic Wishbone B.3 master interface. Two instances are used, one per port. Each converts the core's combinational request into a registered Wishbone cycle. While the cycle is outstanding it raises a stall request to `ctrl`. A small holding state keeps read data stable while the pipeline is still frozen by other stall sources.

## Interface
Parameters:
- none; address/data widths fixed at 32 (`RegBus`), byte selects at 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  6  pipeline stall vector from `ctrl`
- flush_i  in  1  pipeline flush; abort the current transaction (tied 0 until exception support lands)
- cpu_ce_i  in  1  CPU request valid
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  write data
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_sel_i  in  4  byte lane enables
- cpu_data_o  out  32  read data to the CPU
- stallreq  out  1  stall request to `ctrl`
- wishbone_data_i  in  32  slave read data
- wishbone_ack_i  in  1  slave acknowledge
- wishbone_addr_o  out  32  registered address
- wishbone_data_o  out  32  registered write data
- wishbone_we_o  out  1  registered write enable
- wishbone_sel_o  out  4  registered byte selects
- wishbone_stb_o  out  1  registered strobe
- wishbone_cyc_o  out  1  registered cycle

## Operation
- State register has three states: IDLE, BUSY, WAIT_FOR_STALL. A 32-bit `rd_buf` holds read data.
- IDLE:
  - If `cpu_ce_i && !flush_i`, register `addr/data/we/sel` from the cpu inputs, set `stb=cyc=1`, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, with `flush_i=1`:
  - Clear all wishbone outputs and `rd_buf`, and go to IDLE.
  - Flush takes priority over ack.
- BUSY, with `wishbone_ack_i=1`:
  - Clear `stb/cyc/we/sel/addr/data`.
  - If the registered `we` is 0, load `rd_buf` with `wishbone_data_i`.
  - If `stall_i != 0`, go to WAIT_FOR_STALL; otherwise go to IDLE.
- BUSY, no ack: hold all outputs unchanged; `stb`, `addr` and `data` stay stable until ack.
- WAIT_FOR_STALL:
  - Go to IDLE when `stall_i == 6'b0`; `flush_i=1` also forces IDLE.
  - The wishbone outputs stay 0.
- `stallreq` and `cpu_data_o` are combinational from state and inputs:
  - IDLE: `stallreq = cpu_ce_i && !flush_i`; `cpu_data_o = 0`.
  - BUSY with ack: `stallreq = 0`; `cpu_data_o` = `wishbone_data_i` for a read, 0 for a write.
  - BUSY without ack: `stallreq = 1`; `cpu_data_o = 0`.
  - WAIT_FOR_STALL: `stallreq = 0`; `cpu_data_o = rd_buf`.
- Any `flush_i=1` forces `stallreq = 0`.
- `wishbone_ack_i` outside BUSY is ignored.
- Single transfers only: no bursts, no retry/error handling.

## Timing
- Reset (rst=1 at edge): state IDLE, `rd_buf=0`, all wishbone outputs 0. While rst=1, `stallreq=0` and `cpu_data_o=0`.
- Reset mid-transaction: `cyc/stb` drop at the same edge and no data is returned.
- Request presented in cycle N (IDLE) → `stallreq=1` in N; `cyc/stb` high from N+1.
- Minimum latency (ack in N+1) → data on `cpu_data_o` and `stallreq=0` in N+1. Total 2 cycles per access.
- Each wait state of the slave adds one cycle of `stallreq=1`.
- Back-to-back: after return to IDLE, a new request starts the next cycle; there is no idle bus cycle except the IDLE sampling cycle.
- Read data returned from WAIT_FOR_STALL stays constant every cycle until `stall_i` clears.

## Test plan
- Read, zero wait: IDLE, `cpu_ce_i=1, we=0, addr=0x0000_0100`; slave acks in N+1 with `0xDEADBEEF`.
  - Required: `stallreq` 1 in N and 0 in N+1; `cpu_data_o=0xDEADBEEF` in N+1; `cyc/stb` 0 at N+2.
- Write, 3 wait states: `we=1, sel=4'b0011, data=0x1234_5678`.
  - Required: `wishbone_*` stable for 4 cycles; `stallreq=1` for 4 cycles; `cpu_data_o=0` throughout.
- Read with external stall: ack arrives while `stall_i=6'b001111` for 3 more cycles.
  - Required: FSM in WAIT_FOR_STALL; `cpu_data_o` holds the read value with `stallreq=0` for 3 cycles, then IDLE.
- Flush during BUSY, coincident with ack: `flush_i=1`.
  - Required: outputs cleared next edge; `rd_buf=0`; `stallreq=0`; next state IDLE; read data discarded.
- Reset mid-transaction: rst=1 in cycle 2 of BUSY.
  - Required: `cyc=stb=0` and IDLE after that edge; a stray ack afterwards produces no `cpu_data_o` change.
- Back-to-back reads at 0x0 then 0x4, zero wait.
  - Required: second `cyc/stb` asserts exactly 2 cycles after the first; each `stallreq` pulse is 1 cycle.

Source files
------------

// File: rtl/wishbone_bus_if.sv
// Bridge from a single-cycle CPU memory port to a Wishbone B.3 master.
// One registered single transfer at a time; read data is held while the pipeline stays stalled.
module wishbone_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o
);

  localparam logic [1:0] S_IDLE           = 2'd0;
  localparam logic [1:0] S_BUSY           = 2'd1;
  localparam logic [1:0] S_WAIT_FOR_STALL = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] data_q,   data_d;
  logic        we_q,     we_d;
  logic [3:0]  sel_q,    sel_d;
  logic        stb_q,    stb_d;
  logic        cyc_q,    cyc_d;

  always_comb begin
    state_d  = state_q;
    rd_buf_d = rd_buf_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Flush wins over a coincident ack; the returned read data is dropped.
        if (flush_i) begin
          addr_d   = '0;
          data_d   = '0;
          we_d     = 1'b0;
          sel_d    = '0;
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = '0;
          state_d  = S_IDLE;
        end else if (wishbone_ack_i) begin
          addr_d  = '0;
          data_d  = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          if (!we_q) begin
            rd_buf_d = wishbone_data_i;
          end
          state_d = (stall_i != 6'b0) ? S_WAIT_FOR_STALL : S_IDLE;
        end
      end
      S_WAIT_FOR_STALL: begin
        if (flush_i || stall_i == 6'b0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_buf_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_buf_q <= rd_buf_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: stallreq = cpu_ce_i && !flush_i;
        S_BUSY: begin
          if (!flush_i) begin
            if (wishbone_ack_i) begin
              if (!we_q) begin
                cpu_data_o = wishbone_data_i;
              end
            end else begin
              stallreq = 1'b1;
            end
          end
        end
        S_WAIT_FOR_STALL: cpu_data_o = rd_buf_q;
        default: ;
      endcase
    end
  end

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = data_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = stb_q;
  assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Self-checking bench for wishbone_bus_if: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  always #5 clk = ~clk;

  wishbone_bus_if dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .cpu_ce_i        (cpu_ce_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_we_i        (cpu_we_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_data_o      (cpu_data_o),
    .stallreq        (stallreq),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_ack_i  (wishbone_ack_i),
    .wishbone_addr_o (wishbone_addr_o),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_we_o   (wishbone_we_o),
    .wishbone_sel_o  (wishbone_sel_o),
    .wishbone_stb_o  (wishbone_stb_o),
    .wishbone_cyc_o  (wishbone_cyc_o)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Transaction-level model: one outstanding request, plus a "holding" flag for
  // returned read data while the pipeline is still frozen.
  bit          m_out;
  logic [31:0] m_addr, m_data;
  bit          m_we;
  logic [3:0]  m_sel;
  bit          m_hold;
  logic [31:0] m_rd;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic        exp_stall;
    logic [31:0] exp_cd;
    exp_stall = 1'b0;
    exp_cd    = '0;
    if (rst) begin
      exp_stall = 1'b0;
    end else if (m_out) begin
      if (!flush_i) begin
        if (wishbone_ack_i) exp_cd = m_we ? 32'h0 : wishbone_data_i;
        else                exp_stall = 1'b1;
      end
    end else if (m_hold) begin
      exp_cd = m_rd;
    end else begin
      exp_stall = cpu_ce_i && !flush_i;
    end
    check1 ("stallreq",   stallreq,        exp_stall);
    check32("cpu_data_o", cpu_data_o,      exp_cd);
    check32("wb_addr",    wishbone_addr_o, m_out ? m_addr : 32'h0);
    check32("wb_data",    wishbone_data_o, m_out ? m_data : 32'h0);
    check1 ("wb_we",      wishbone_we_o,   m_out ? m_we : 1'b0);
    check32("wb_sel",     {28'h0, wishbone_sel_o}, m_out ? {28'h0, m_sel} : 32'h0);
    check1 ("wb_stb",     wishbone_stb_o,  m_out);
    check1 ("wb_cyc",     wishbone_cyc_o,  m_out);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_out  = 1'b0;
      m_hold = 1'b0;
      m_rd   = '0;
    end else if (m_out) begin
      if (flush_i) begin
        m_out = 1'b0;
        m_rd  = '0;
      end else if (wishbone_ack_i) begin
        m_out = 1'b0;
        if (!m_we) m_rd = wishbone_data_i;
        m_hold = (stall_i != 6'b0);
      end
    end else if (m_hold) begin
      if (flush_i || stall_i == 6'b0) m_hold = 1'b0;
    end else if (cpu_ce_i && !flush_i) begin
      m_out  = 1'b1;
      m_addr = cpu_addr_i;
      m_data = cpu_data_i;
      m_we   = cpu_we_i;
      m_sel  = cpu_sel_i;
    end
  endtask

  // Called just after a falling edge with inputs set.
  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    rst             = 1'b0;
    stall_i         = '0;
    flush_i         = 1'b0;
    cpu_ce_i        = 1'b0;
    cpu_addr_i      = '0;
    cpu_data_i      = '0;
    cpu_we_i        = 1'b0;
    cpu_sel_i       = '0;
    wishbone_ack_i  = 1'b0;
    wishbone_data_i = $urandom;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = data;
    cpu_sel_i  = sel;
  endtask

  initial begin
    m_out = 1'b0; m_hold = 1'b0; m_rd = '0;
    m_addr = '0; m_data = '0; m_we = 1'b0; m_sel = '0;
    quiet();
    rst = 1'b1;
    advance();
    settle();
    check1("reset_cyc", wishbone_cyc_o, 1'b0);
    check1("reset_stallreq", stallreq, 1'b0);
    advance();

    // Read, zero wait states
    quiet(); request(1'b0, 32'h0000_0100, 32'h0, 4'hf);
    settle(); check1("rd0_stall_N", stallreq, 1'b1);
    advance();
    quiet(); wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
    settle();
    check32("rd0_data_N1", cpu_data_o, 32'hDEAD_BEEF);
    check1("rd0_stall_N1", stallreq, 1'b0);
    check32("rd0_addr_N1", wishbone_addr_o, 32'h0000_0100);
    advance();
    quiet();
    settle(); check1("rd0_cyc_N2", wishbone_cyc_o, 1'b0);
    advance();

    // Write, 3 wait states
    quiet(); request(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
    settle(); check1("wr3_stall_N", stallreq, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin
      quiet(); wishbone_ack_i = (i == 3);
      settle();
      check32("wr3_data", wishbone_data_o, 32'h1234_5678);
      check1("wr3_stb", wishbone_stb_o, 1'b1);
      check1("wr3_stall", stallreq, (i != 3));
      check32("wr3_cpu_data", cpu_data_o, 32'h0);
      advance();
    end
    quiet();
    settle(); check1("wr3_cyc_after", wishbone_cyc_o, 1'b0);
    advance();

    // Read completing under an external stall
    quiet(); request(1'b0, 32'h0000_0300, 32'h0, 4'hf);
    settle(); advance();
    quiet(); wishbone_ack_i = 1'b1; wishbone_data_i = 32'hCAFE_F00D; stall_i = 6'b001111;
    settle(); check32("ws_ack_data", cpu_data_o, 32'hCAFE_F00D);
    advance();
    for (int i = 0; i < 3; i++) begin
      quiet(); stall_i = 6'b001111; wishbone_ack_i = (i == 1);
      settle();
      check32("ws_hold_data", cpu_data_o, 32'hCAFE_F00D);
      check1("ws_hold_stall", stallreq, 1'b0);
      advance();
    end
    quiet();
    settle(); check32("ws_release_data", cpu_data_o, 32'hCAFE_F00D);
    advance();
    quiet();
    settle(); check32("ws_idle_data", cpu_data_o, 32'h0);
    advance();

    // Flush coincident with ack, then show the held-read buffer was cleared
    quiet(); request(1'b0, 32'h0000_0400, 32'h0, 4'hf);
    settle(); advance();
    quiet(); flush_i = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1111_2222;
    settle(); check1("fl_stall", stallreq, 1'b0);
    advance();
    quiet();
    settle();
    check1("fl_cyc", wishbone_cyc_o, 1'b0);
    check32("fl_addr", wishbone_addr_o, 32'h0);
    advance();
    quiet(); request(1'b1, 32'h0000_0500, 32'hAAAA_5555, 4'hf);
    settle(); advance();
    quiet(); wishbone_ack_i = 1'b1; stall_i = 6'b000001;
    settle(); advance();
    quiet(); stall_i = 6'b000001;
    settle(); check32("fl_rdbuf_cleared", cpu_data_o, 32'h0);
    advance();
    quiet(); settle(); advance();

    // Reset in the second BUSY cycle, then a stray ack
    quiet(); request(1'b0, 32'h0000_0600, 32'h0, 4'hf);
    settle(); advance();
    quiet(); settle(); advance();
    quiet(); rst = 1'b1;
    settle(); check1("rst_mid_stall", stallreq, 1'b0);
    advance();
    quiet(); wishbone_ack_i = 1'b1; wishbone_data_i = 32'h5555_AAAA;
    settle();
    check1("rst_mid_cyc", wishbone_cyc_o, 1'b0);
    check1("rst_mid_stb", wishbone_stb_o, 1'b0);
    check32("rst_mid_stray", cpu_data_o, 32'h0);
    advance();

    // Back-to-back reads at 0x0 and 0x4
    quiet(); request(1'b0, 32'h0, 32'h0, 4'hf);
    settle(); check1("b2b_stall0", stallreq, 1'b1);
    advance();
    request(1'b0, 32'h0, 32'h0, 4'hf); wishbone_ack_i = 1'b1;
    settle(); check1("b2b_cyc1", wishbone_cyc_o, 1'b1); check1("b2b_stall1", stallreq, 1'b0);
    advance();
    quiet(); request(1'b0, 32'h4, 32'h0, 4'hf);
    settle(); check1("b2b_cyc2", wishbone_cyc_o, 1'b0); check1("b2b_stall2", stallreq, 1'b1);
    advance();
    quiet(); wishbone_ack_i = 1'b1;
    settle();
    check1("b2b_cyc3", wishbone_cyc_o, 1'b1);
    check32("b2b_addr3", wishbone_addr_o, 32'h4);
    check1("b2b_stall3", stallreq, 1'b0);
    advance();

    // Random traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) == 0);
      flush_i         = ($urandom_range(0, 15) == 0);
      stall_i         = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      cpu_ce_i        = $urandom_range(0, 1);
      cpu_we_i        = $urandom_range(0, 1);
      cpu_addr_i      = $urandom;
      cpu_data_i      = $urandom;
      cpu_sel_i       = 4'($urandom);
      wishbone_ack_i  = ($urandom_range(0, 2) == 0);
      wishbone_data_i = $urandom;
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
